// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA horizontal/vertical sync and pixel coordinate generator
//
// Purpose: free-running 2-D raster counter that advances one pixel per PixelEn
// strobe. Syncs and the visible-area flag are decoded straight from the
// counter registers, so they stay aligned with PixelX/PixelY.
//
// Ports:
//   CLK        in   system clock, rising-edge
//   RST        in   synchronous reset, active-high, wins over PixelEn
//   PixelEn    in   one-CLK pixel strobe
//   HSync      out  horizontal sync, active-low
//   VSync      out  vertical sync, active-low
//   Video_On   out  high inside the visible area
//   PixelX     out  [9:0] horizontal count
//   PixelY     out  [9:0] vertical count
//   FrameTick  out  one-CLK pulse after the end-of-frame wrap
//
// Build option: VGA_SYNC_FRAMETICK_EN enables FrameTick; when undefined the
// port is tied low and no pulse logic exists.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PixelEn,
  output logic       HSync,
  output logic       VSync,
  output logic       Video_On,
  output logic [9:0] PixelX,
  output logic [9:0] PixelY,
  output logic       FrameTick
);

  localparam int H_TOT = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    // The line counter only moves on the pixel that closes a line.
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else if (PixelEn) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign PixelX   = h_q;
  assign PixelY   = v_q;
  assign HSync    = !((h_q >= HS_START) && (h_q <= HS_END));
  assign VSync    = !((v_q >= VS_START) && (v_q <= VS_END));
  assign Video_On = (h_q < H_VIS) && (v_q < V_VIS);

`ifdef VGA_SYNC_FRAMETICK_EN
  logic frame_tick_q;

  // Set only by a strobe that wraps both counters, and cleared on the very
  // next edge even without a strobe, so the pulse is always one CLK wide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= PixelEn && h_wrap && v_wrap;
    end
  end

  assign FrameTick = frame_tick_q;
`else
  assign FrameTick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

`ifdef VGA_SYNC_FRAMETICK_EN
  localparam bit FT_ON = 1'b1;
`else
  localparam bit FT_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst = 1'b1, en = 1'b0;
  logic       s_rst = 1'b1, s_en = 1'b0;
  logic       hs, vs, vo, ft;
  logic [9:0] px, py;
  logic       s_hs, s_vs, s_vo, s_ft;
  logic [9:0] s_px, s_py;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Default 640x480 timing.
  vga_sync_gen dut (
    .CLK(CLK), .RST(rst), .PixelEn(en),
    .HSync(hs), .VSync(vs), .Video_On(vo),
    .PixelX(px), .PixelY(py), .FrameTick(ft)
  );

  // Reduced timing so whole frames fit in a short run:
  // H 8+2+3+2=15 (hsync 10..12), V 4+1+2+1=8 (vsync 5..6), frame 120 strobes.
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .CLK(CLK), .RST(s_rst), .PixelEn(s_en),
    .HSync(s_hs), .VSync(s_vs), .Video_On(s_vo),
    .PixelX(s_px), .PixelY(s_py), .FrameTick(s_ft)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int first_hs, last_hs, hs_cnt, first_vo_lo, vo_hi;
  int vs_cnt, first_vs_x, first_vs_y, ft_cnt, dev;
  logic [9:0] hold_px, hold_py;
  logic hold_hs, hold_vs, hold_vo, hold_ft;

  initial begin
    // Reset: 3 edges with strobes on, outputs pinned at origin.
    rst = 1'b1; en = 1'b1; s_rst = 1'b1; s_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_px", px, 0);
    end
    rst = 1'b0; en = 1'b0; s_rst = 1'b0; s_en = 1'b0;
    tick();
    check("rst_px", px, 0);
    check("rst_py", py, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_vo", vo, 1);
    check("rst_ft", ft, 0);
    check("rst_s_ft", s_ft, 0);

    // Horizontal timing: one strobe every 4th CLK for a full line.
    first_hs = -1; last_hs = -1; hs_cnt = 0; first_vo_lo = -1; vo_hi = 0;
    for (int k = 1; k <= 800; k++) begin
      en = 1'b1; tick();
      en = 1'b0;
      if (hs == 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(px);
        last_hs = int'(px);
      end
      if (vo) vo_hi++;
      else if (first_vo_lo < 0) first_vo_lo = int'(px);
      tick(); tick(); tick();
    end
    check("h_sync_width", hs_cnt, 96);
    check("h_sync_first", first_hs, 656);
    check("h_sync_last", last_hs, 751);
    check("h_vo_fall", first_vo_lo, 640);
    check("h_vo_count", vo_hi, 640);
    check("h_line_px", px, 0);
    check("h_line_py", py, 1);

    // Stall at PixelX=100.
    en = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    en = 1'b0;
    check("stall_start_px", px, 100);
    hold_px = px; hold_py = py; hold_hs = hs; hold_vs = vs; hold_vo = vo; hold_ft = ft;
    dev = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (px !== hold_px || py !== hold_py || hs !== hold_hs ||
          vs !== hold_vs || vo !== hold_vo || ft !== hold_ft) dev++;
    end
    check("stall_hold", dev, 0);
    en = 1'b1; tick(); en = 1'b0;
    check("stall_resume_px", px, 101);

    // Mid-line reset on the default instance at (700,1), inside hsync.
    en = 1'b1;
    for (int k = 0; k < 599; k++) tick();
    check("pre_rst_px", px, 700);
    check("pre_rst_hs", hs, 0);
    check("pre_rst_vo", vo, 0);
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;
    check("mid_rst_px", px, 0);
    check("mid_rst_py", py, 0);
    check("mid_rst_hs", hs, 1);
    check("mid_rst_vs", vs, 1);
    check("mid_rst_vo", vo, 1);

    // Vertical timing and FrameTick on the reduced instance, strobe every 2nd CLK.
    vs_cnt = 0; first_vs_x = -1; first_vs_y = -1; ft_cnt = 0;
    for (int k = 1; k <= 240; k++) begin
      s_en = 1'b1; tick(); s_en = 1'b0;
      if (s_ft) ft_cnt++;
      if (k <= 120 && s_vs == 1'b0) begin
        vs_cnt++;
        if (first_vs_x < 0) begin
          first_vs_x = int'(s_px);
          first_vs_y = int'(s_py);
        end
      end
      if (k == 120) begin
        check("v_frame_px", s_px, 0);
        check("v_frame_py", s_py, 0);
        check("ft_after_wrap", s_ft, FT_ON);
      end
      tick();
      if (s_ft) ft_cnt++;
      if (k == 120) check("ft_one_cycle", s_ft, 0);
    end
    check("v_sync_width", vs_cnt, 30);
    check("v_sync_first_x", first_vs_x, 0);
    check("v_sync_first_y", first_vs_y, 5);
    check("ft_count_2frames", ft_cnt, FT_ON ? 2 : 0);

    // Mid-frame reset on the reduced instance at (11,5): both syncs low.
    s_en = 1'b1;
    for (int k = 0; k < 86; k++) tick();
    check("s_pre_rst_px", s_px, 11);
    check("s_pre_rst_py", s_py, 5);
    check("s_pre_rst_hs", s_hs, 0);
    check("s_pre_rst_vs", s_vs, 0);
    s_rst = 1'b1; tick(); s_rst = 1'b0; s_en = 1'b0;
    check("s_mid_rst_px", s_px, 0);
    check("s_mid_rst_py", s_py, 0);
    check("s_mid_rst_hs", s_hs, 1);
    check("s_mid_rst_vs", s_vs, 1);
    check("s_mid_rst_vo", s_vo, 1);
    check("s_mid_rst_ft", s_ft, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-002 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-003 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-005 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-006 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-007 Parameter V_FP, 10, vertical front porch in lines.
REQ-008 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-009 Parameter V_BP, 33, vertical back porch in lines.
REQ-010 CLK  input  1  system clock; all state updates on its rising edge.
REQ-011 RST  input  1  synchronous reset, active-high.
REQ-012 PixelEn  input  1  pixel-rate strobe from the frequency divider; one CLK-wide pulse per pixel.
REQ-013 HSync  output  1  horizontal sync, active-low.
REQ-014 VSync  output  1  vertical sync, active-low.
REQ-015 Video_On  output  1  high while the current pixel is in the visible area.
REQ-016 PixelX  output  10  current horizontal count.
REQ-017 PixelY  output  10  current vertical count.
REQ-018 FrameTick  output  1  start-of-frame pulse (see Configuration).

Function
REQ-019 H_TOT = H_DISPLAY+H_FP+H_SYNC+H_BP and V_TOT = V_DISPLAY+V_FP+V_SYNC+V_BP; both SHALL be at most 1024, unchecked otherwise.
REQ-020 The horizontal counter SHALL advance by 1 only on CLK edges where PixelEn=1; it SHALL wrap from H_TOT-1 to 0.
REQ-021 The vertical counter SHALL advance by 1 only on the edge where the horizontal counter wraps; it SHALL wrap from V_TOT-1 to 0 on that same edge.
REQ-022 With PixelEn=0, both counters and all outputs SHALL hold their values.
REQ-023 PixelX/PixelY SHALL equal the horizontal/vertical counter registers, with zero added latency.
REQ-024 HSync SHALL be 0 iff PixelX is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] (defaults 656..751), else 1.
REQ-025 VSync SHALL be 0 iff PixelY is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] (defaults 490..491), else 1.
REQ-026 Video_On SHALL be 1 iff PixelX<H_DISPLAY and PixelY<V_DISPLAY.
REQ-027 HSync, VSync and Video_On SHALL be decoded from the same counter registers, so they stay cycle-aligned with PixelX/PixelY.

Reset
REQ-028 RST=1 at a rising CLK edge SHALL set both counters to 0, regardless of PixelEn; RST takes priority over PixelEn.
REQ-029 During and after reset: PixelX=0, PixelY=0, HSync=1, VSync=1, Video_On=1, FrameTick=0.
REQ-030 Reset asserted mid-frame SHALL restart timing at (0,0) on the next edge, with no partial-line completion.

Configuration
REQ-031 Macro VGA_SYNC_FRAMETICK_EN controls the FrameTick pulse.
REQ-032 With the macro defined, FrameTick SHALL be 1 for exactly one CLK cycle: the cycle after the edge on which the counters wrap from (H_TOT-1, V_TOT-1) to (0,0).
REQ-033 FrameTick SHALL NOT pulse on leaving reset.
REQ-034 With the macro undefined, FrameTick SHALL be tied 0, the port SHALL remain, and the pulse logic SHALL be absent.

Verification
REQ-035 Reset: hold RST=1 for 3 CLK with PixelEn=1, then release -> PixelX=0, PixelY=0, HSync=1, VSync=1, Video_On=1, FrameTick=0.
REQ-036 Horizontal timing: PixelEn every 4th CLK -> HSync low for exactly 96 strobes starting at PixelX=656; Video_On falls at PixelX=640; line period 800 strobes.
REQ-037 Vertical timing: VSync low for exactly 1600 strobes starting at PixelY=490, PixelX=0; frame period 420000 strobes.
REQ-038 Stall: PixelEn=0 for 50 CLK at PixelX=100 -> all outputs constant for those 50 cycles, then counting resumes at 101.
REQ-039 Mid-frame reset: RST=1 for one edge at (700,300) -> next cycle PixelX=0, PixelY=0, HSync=1, VSync=1.
REQ-040 FrameTick: macro defined -> one 1-CLK pulse per 420000 strobes, in the cycle after the (799,524)->(0,0) wrap; macro undefined -> FrameTick constant 0 over 2 frames.
